rom_stream_reader: RTL and testbench

Read initiator for the synchronous ROM (14-bit address, 24-bit data, `read_enable`, registered `data_out`). It takes a burst request (start address, word count), issues one ROM read per cycle, tracks reads in flight, and buffers returned words in a small FIFO. Words leave on a valid/ready stream with backpressure. It sits between the ROM and any consumer that needs sequential table or coefficient data, and replaces testbench-driven address sweeps.

---
 rtl/rom_reader_pkg.sv | 22 ++
 rtl/rom_stream_reader_if.sv | 29 ++
 rtl/rom_rd_fifo.sv | 63 ++++++
 rtl/rom_rd_fifo_chk.sv | 12 +
 rtl/rom_stream_reader.sv | 133 +++++++++++++
 tb/tb_rom_stream_reader.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM stream reader and its output FIFO.
package rom_reader_pkg;

  localparam int ROM_ADDR_W = 14;
  localparam int ROM_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    if (depth <= 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// Request, ROM and output-stream signals of the reader; master is the reader side.
interface rom_stream_reader_if
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_read_enable;
  logic [DATA_W-1:0] rom_data_out;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    input  start, start_addr, length, rom_data_out, dout_ready,
    output busy, done, rom_address, rom_read_enable, dout, dout_valid
  );

  modport slave (
    output start, start_addr, length, rom_data_out, dout_ready,
    input  busy, done, rom_address, rom_read_enable, dout, dout_valid
  );
endinterface

// File: rtl/rom_rd_fifo.sv
// Synchronous FIFO with a cleared storage array so the read port shows zero after reset.
module rom_rd_fifo
  import rom_reader_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic [ptr_w(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == (PTR_W+1)'(DEPTH));
  assign empty = (count_r == {(PTR_W+1){1'b0}});

  rom_rd_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: rtl/rom_rd_fifo_chk.sv
// Simulation-only protocol checks for the output FIFO.
module rom_rd_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/rom_stream_reader.sv
// Burst read initiator: issues sequential ROM reads, tracks reads in flight and
// streams the returned words out through a small FIFO with backpressure.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = ROM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ROM_LAT    = 1
) (
  input logic                 clk,
  input logic                 rst,
  rom_stream_reader_if.master bus
);
  localparam int CNT_W = ptr_w(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + $clog2(ROM_LAT + 2);
  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);

  state_t            state_r, state_next_s;
  logic [ADDR_W:0]   issue_left_r, accept_left_r;
  logic [ROM_LAT-1:0] pend_r;
  logic              busy_r, done_r, rre_r;
  logic [ADDR_W-1:0] addr_r;
  logic [OCC_W-1:0]  occupancy_s;
  logic              issue_next_s, last_xfer_s, push_s, pop_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0] fifo_dout_s;

  assign push_s = pend_r[ROM_LAT-1];
  assign pop_s  = !fifo_empty_s && bus.dout_ready;

  // Reads in flight count against FIFO space so a returning word always fits.
  always_comb begin
    occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(rre_r);
    for (int i = 0; i < ROM_LAT; i++) begin
      occupancy_s = occupancy_s + OCC_W'(pend_r[i]);
    end
    issue_next_s = (state_r == RUN) && (issue_left_r != LEN_ZERO) && !fifo_full_s
                   && (occupancy_s < OCC_W'(FIFO_DEPTH));
    last_xfer_s  = (state_r != IDLE) && pop_s && (accept_left_r == LEN_ONE);
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start && (bus.length != LEN_ZERO)) state_next_s = RUN;
        else                                       state_next_s = IDLE;
      end
      RUN: begin
        if (last_xfer_s)                                    state_next_s = IDLE;
        else if ((issue_left_r == LEN_ZERO) ||
                 (issue_next_s && (issue_left_r == LEN_ONE))) state_next_s = DRAIN;
        else                                                state_next_s = RUN;
      end
      DRAIN: begin
        if (last_xfer_s) state_next_s = IDLE;
        else             state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Counters, ROM strobe/address, in-flight flags and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_left_r  <= LEN_ZERO;
      accept_left_r <= LEN_ZERO;
      pend_r        <= {ROM_LAT{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rre_r         <= 1'b0;
      addr_r        <= {ADDR_W{1'b0}};
    end else begin
      pend_r[0] <= rre_r;
      for (int i = 1; i < ROM_LAT; i++) begin
        pend_r[i] <= pend_r[i-1];
      end
      if (pop_s) begin
        accept_left_r <= accept_left_r - LEN_ONE;
      end
      case (state_r)
        IDLE: begin
          busy_r <= bus.start && (bus.length != LEN_ZERO);
          done_r <= bus.start && (bus.length == LEN_ZERO);
          rre_r  <= bus.start && (bus.length != LEN_ZERO);
          if (bus.start && (bus.length != LEN_ZERO)) begin
            addr_r        <= bus.start_addr;
            issue_left_r  <= bus.length - LEN_ONE;
            accept_left_r <= bus.length;
          end
        end
        default: begin
          busy_r <= 1'b1;
          done_r <= last_xfer_s;
          rre_r  <= issue_next_s;
          if (issue_next_s) begin
            addr_r       <= addr_r + ADDR_W'(1);
            issue_left_r <= issue_left_r - LEN_ONE;
          end
        end
      endcase
    end
  end

  rom_rd_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.rom_data_out),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.rom_read_enable = rre_r;
  assign bus.rom_address     = addr_r;
  assign bus.dout            = fifo_dout_s;
  assign bus.dout_valid      = !fifo_empty_s;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a ROM model holding mem[i] = i.
module tb_rom_stream_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  rom_stream_reader_if #(.ADDR_W(14), .DATA_W(24)) bus ();

  rom_stream_reader #(.ADDR_W(14), .DATA_W(24), .FIFO_DEPTH(4), .ROM_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rom_read_enable) bus.rom_data_out <= {10'b0, bus.rom_address};
  end

  logic [23:0] got[$];
  int first_valid, done_cyc, done_pulses, max_out, stall_changes, busy_bad, rre_gaps;
  logic [31:0] pat = 32'b1100_0000_1011_0001_1110_0100_0000_1101;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one burst and records what the stream, strobe and status outputs did.
  task automatic run_burst(input logic [13:0] addr, input logic [14:0] len,
                           input int mode, input int rc, input int budget);
    int issued, accepted;
    logic prev_stall;
    logic [23:0] prev_dout;
    got.delete();
    first_valid = -1; done_cyc = -1; done_pulses = 0; max_out = 0;
    stall_changes = 0; busy_bad = 0; rre_gaps = 0;
    issued = 0; accepted = 0; prev_stall = 1'b0; prev_dout = 24'd0;
    bus.dout_ready = 1'b1;
    bus.start = 1'b1; bus.start_addr = addr; bus.length = len;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      bus.dout_ready = (mode == 0) ? 1'b1 : pat[c % 32];
      if (bus.rom_read_enable) issued++;
      if (!bus.rom_read_enable && issued > 0 && issued < int'(len)) rre_gaps++;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (bus.dout_valid && first_valid < 0) first_valid = c;
      if (prev_stall && (!bus.dout_valid || bus.dout !== prev_dout)) stall_changes++;
      if (bus.done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if ((done_cyc < 0 || c == done_cyc) && !bus.busy) busy_bad++;
      else if (c == done_cyc + 1 && bus.busy) busy_bad++;
      if (bus.dout_valid && bus.dout_ready) begin
        got.push_back(bus.dout);
        accepted++;
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      bus.start = (c + 1 == rc);
      if (c + 1 == rc) begin
        bus.start_addr = 14'd500; bus.length = 15'd3;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.start_addr = 14'd0; bus.length = 15'd0; bus.dout_ready = 1'b1;
    tick(); tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.rom_read_enable !== 1'b0) begin miscompares++; $display("FAIL reset_rre: got %b expected 0", bus.rom_read_enable); end
    vectors++; if (bus.rom_address !== 14'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", bus.rom_address); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.dout_valid); end
    vectors++; if (bus.dout !== 24'd0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0", bus.dout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_burst(14'd16, 15'd8, 0, -1, 100);
    vectors++; if (got.size() !== 8) begin miscompares++; $display("FAIL basic_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 24'(16 + i)) begin miscompares++; $display("FAIL basic_word[%0d]: got %h expected %h", i, got[i], 24'(16 + i)); end
    end
    vectors++; if (first_valid !== 3) begin miscompares++; $display("FAIL basic_first_valid: got %0d expected 3", first_valid); end
    vectors++; if (done_cyc !== 11) begin miscompares++; $display("FAIL basic_done_cycle: got %0d expected 11", done_cyc); end
    vectors++; if (done_pulses !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
    vectors++; if (busy_bad !== 0) begin miscompares++; $display("FAIL basic_busy: got %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_wrap();
    run_burst(14'd16380, 15'd8, 0, -1, 100);
    vectors++; if (got.size() !== 8) begin miscompares++; $display("FAIL wrap_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 24'((16380 + i) % 16384)) begin miscompares++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, got[i], 24'((16380 + i) % 16384)); end
    end
    vectors++; if (done_cyc !== 11) begin miscompares++; $display("FAIL wrap_done_cycle: got %0d expected 11", done_cyc); end
  endtask

  task automatic test_backpressure();
    run_burst(14'd100, 15'd16, 1, -1, 300);
    vectors++; if (got.size() !== 16) begin miscompares++; $display("FAIL bp_count: got %0d expected 16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 24'(100 + i)) begin miscompares++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got[i], 24'(100 + i)); end
    end
    vectors++; if (max_out > 4) begin miscompares++; $display("FAIL bp_occupancy: got %0d expected at most 4", max_out); end
    vectors++; if (stall_changes !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d changes expected 0", stall_changes); end
    vectors++; if (rre_gaps == 0) begin miscompares++; $display("FAIL bp_rre_throttle: got %0d gap cycles expected >0", rre_gaps); end
    vectors++; if (done_pulses !== 1) begin miscompares++; $display("FAIL bp_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_zero_length();
    int rre_seen;
    rre_seen = 0;
    bus.start = 1'b1; bus.start_addr = 14'd77; bus.length = 15'd0;
    tick();
    bus.start = 1'b0;
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", bus.done); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b expected 0", bus.busy); end
    if (bus.rom_read_enable) rre_seen++;
    tick();
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse: got %b expected 0", bus.done); end
    for (int c = 0; c < 4; c++) begin
      if (bus.rom_read_enable) rre_seen++;
      tick();
    end
    vectors++; if (rre_seen !== 0) begin miscompares++; $display("FAIL zero_rre: got %0d strobes expected 0", rre_seen); end
  endtask

  task automatic test_ignored_start();
    run_burst(14'd200, 15'd6, 0, 2, 100);
    vectors++; if (got.size() !== 6) begin miscompares++; $display("FAIL ign_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 24'(200 + i)) begin miscompares++; $display("FAIL ign_word[%0d]: got %h expected %h", i, got[i], 24'(200 + i)); end
    end
    vectors++; if (done_cyc !== 9) begin miscompares++; $display("FAIL ign_done_cycle: got %0d expected 9", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int accepted, done_seen;
    accepted = 0; done_seen = 0;
    bus.dout_ready = 1'b1;
    bus.start = 1'b1; bus.start_addr = 14'd40; bus.length = 15'd32;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 50 && accepted < 5; c++) begin
      if (bus.dout_valid && bus.dout_ready) accepted++;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.rom_read_enable !== 1'b0) begin miscompares++; $display("FAIL rmid_rre: got %b expected 0", bus.rom_read_enable); end
    vectors++; if (bus.rom_address !== 14'd0) begin miscompares++; $display("FAIL rmid_addr: got %h expected 0", bus.rom_address); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b expected 0", bus.dout_valid); end
    vectors++; if (bus.dout !== 24'd0) begin miscompares++; $display("FAIL rmid_dout: got %h expected 0", bus.dout); end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done || bus.rom_read_enable || bus.dout_valid) done_seen++;
      tick();
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", done_seen); end
    run_burst(14'd0, 15'd4, 0, -1, 100);
    vectors++; if (got.size() !== 4) begin miscompares++; $display("FAIL rmid_fresh_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 24'(i)) begin miscompares++; $display("FAIL rmid_fresh_word[%0d]: got %h expected %h", i, got[i], 24'(i)); end
    end
    vectors++; if (done_cyc !== 7) begin miscompares++; $display("FAIL rmid_fresh_done: got %0d expected 7", done_cyc); end
  endtask

  task automatic test_full_range();
    run_burst(14'd0, 15'd16384, 0, -1, 16450);
    vectors++; if (got.size() !== 16384) begin miscompares++; $display("FAIL full_count: got %0d expected 16384", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 24'(i)) begin miscompares++; $display("FAIL full_word[%0d]: got %h expected %h", i, got[i], 24'(i)); end
    end
    vectors++; if (done_cyc !== 16387) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected 16387", done_cyc); end
    vectors++; if (done_pulses !== 1) begin miscompares++; $display("FAIL full_done_pulses: got %0d expected 1", done_pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_ignored_start();
    test_reset_mid();
    test_full_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
